// File: rtl/point_store_if.sv
// Bus between the core and the point store unit: start request, point operand,
// status flags and the word-wide memory port.
interface point_store_if #(
  parameter int WORDS = 8
);
  logic                   start;
  logic [31:0]            base_addr;
  logic [32*WORDS-1:0]    point_data;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [3:0]             err_idx;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic                   mem_we;
  logic [31:0]            mem_rdata;

  modport master (
    output start, base_addr, point_data, mem_rdata,
    input  busy, done, err, err_idx, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  start, base_addr, point_data, mem_rdata,
    output busy, done, err, err_idx, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/point_store_unit.sv
// Writes a WORDS x 32-bit point to consecutive word addresses starting at base.
// Define POINT_STORE_READBACK_EN to read back and compare each word after writing it.
module point_store_unit #(
  parameter int WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  point_store_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
`ifdef POINT_STORE_READBACK_EN
    READ,
`endif
    DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          idx_reg, idx_next;
  logic [32*WORDS-1:0] point_reg, point_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [31:0]         mem_addr_reg, mem_addr_next;
  logic [31:0]         mem_wdata_reg, mem_wdata_next;
  logic                mem_we_reg, mem_we_next;
`ifdef POINT_STORE_READBACK_EN
  logic                err_reg, err_next;
  logic [3:0]          err_idx_reg, err_idx_next;
`endif

  // Fixed 16-entry view so a 4-bit index never runs past the array.
  logic [31:0] word_arr [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
      if (gi < WORDS) begin : g_used
        assign word_arr[gi] = point_reg[32*gi +: 32];
      end else begin : g_pad
        assign word_arr[gi] = 32'h0;
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    point_next     = point_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
`ifdef POINT_STORE_READBACK_EN
    err_next       = err_reg;
    err_idx_next   = err_idx_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = WRITE;
          idx_next       = 4'd0;
          point_next     = bus.point_data;
          busy_next      = 1'b1;
          mem_addr_next  = {bus.base_addr[31:2], 2'b00};
          mem_wdata_next = bus.point_data[31:0];
          mem_we_next    = 1'b1;
`ifdef POINT_STORE_READBACK_EN
          err_next       = 1'b0;
          err_idx_next   = 4'd0;
`endif
        end
      end
      WRITE: begin
`ifdef POINT_STORE_READBACK_EN
        // Address is held so the read checks the word just written.
        state_next = READ;
`else
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          idx_next       = idx_reg + 4'd1;
          mem_addr_next  = mem_addr_reg + 32'd4;
          mem_wdata_next = word_arr[idx_reg + 4'd1];
          mem_we_next    = 1'b1;
        end
`endif
      end
`ifdef POINT_STORE_READBACK_EN
      READ: begin
        // Only the first mismatch is recorded.
        if ((bus.mem_rdata != word_arr[idx_reg]) && !err_reg) begin
          err_next     = 1'b1;
          err_idx_next = idx_reg;
        end
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          state_next     = WRITE;
          idx_next       = idx_reg + 4'd1;
          mem_addr_next  = mem_addr_reg + 32'd4;
          mem_wdata_next = word_arr[idx_reg + 4'd1];
          mem_we_next    = 1'b1;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      point_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      mem_we_reg    <= 1'b0;
`ifdef POINT_STORE_READBACK_EN
      err_reg       <= 1'b0;
      err_idx_reg   <= 4'd0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      point_reg     <= point_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
`ifdef POINT_STORE_READBACK_EN
      err_reg       <= err_next;
      err_idx_reg   <= err_idx_next;
`endif
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_we    = mem_we_reg;
`ifdef POINT_STORE_READBACK_EN
  assign bus.err       = err_reg;
  assign bus.err_idx   = err_idx_reg;
`else
  assign bus.err       = 1'b0;
  assign bus.err_idx   = 4'd0;
  wire unused_rdata    = ^bus.mem_rdata;
`endif

endmodule

// File: tb/tb_point_store_unit.sv
// Bench for point_store_unit: word-indexed memory model, write log and done counter,
// checked against addresses/data/latencies derived directly from the store rules.
`timescale 1ns/1ps
module tb_point_store_unit;
  localparam int W = 8;
`ifdef POINT_STORE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int LAT = RB ? 2*W + 1 : W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  point_store_if #(.WORDS(W)) bus();
  point_store_unit #(.WORDS(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  // Memory indexed by address bits [9:2]; test regions are chosen not to alias.
  logic [31:0] mem [256] = '{default: 32'h0};
  logic [63:0] wlog [$];
  int          done_cnt = 0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_base = 32'h0;
  logic [31:0] rd_mask;
  bit          same_addr_viol = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  assign rd_mask = (corrupt_en && (bus.mem_addr == corrupt_base + 32'd12 ||
                                   bus.mem_addr == corrupt_base + 32'd24)) ? 32'h00FF_0000 : 32'h0;
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]] ^ rd_mask;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
    end
    if (bus.mem_we && prev_we && bus.mem_addr == prev_addr) same_addr_viol <= 1'b1;
    prev_we   <= bus.mem_we;
    prev_addr <= bus.mem_addr;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    return {base[31:2], 2'b00} + 32'(4 * i);
  endfunction

  function automatic logic [32*W-1:0] rand_point();
    logic [32*W-1:0] p;
    for (int i = 0; i < W; i++) p[32*i +: 32] = $urandom();
    return p;
  endfunction

  // Issues one start, scrambles the inputs afterwards, re-pulses start in the cycles
  // flagged in repulse, and returns the start-to-done latency (-1 on timeout).
  task automatic run_store(input logic [31:0] base, input logic [32*W-1:0] data,
                           input logic [31:0] repulse, output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.point_data = data;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base_addr = $urandom();
    bus.point_data = rand_point();
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= LAT + 10; n++) begin
      @(negedge clk);
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        bus.start = 1'b0;
        lat = n;
        break;
      end
      bus.start = (n < 32) ? repulse[n] : 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    total++; if (bus.err_idx !== 4'd0) begin bad++; $display("FAIL reset_err_idx: got %0d want 0", bus.err_idx); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [32*W-1:0] data;
    int lat, log0;
    bit busy_ok;
    logic [31:0] ea;
    for (int i = 0; i < W; i++) data[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    log0 = wlog.size();
    run_store(32'h100, data, 32'h0, lat, busy_ok);
    total++; if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
    total++; if (!busy_ok) begin bad++; $display("FAIL basic_busy: got gap want busy through done"); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", bus.err); end
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL basic_after_done: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    total++; if (wlog.size() - log0 != W) begin
      bad++; $display("FAIL basic_we_count: got %0d want %0d", wlog.size() - log0, W); end
    for (int i = 0; i < W; i++) begin
      ea = 32'h100 + 32'(4 * i);
      total++; if (mem[ea[9:2]] !== 32'hA5A5_0000 + 32'(i)) begin
        bad++; $display("FAIL basic_mem[%h]: got %h want %h", ea, mem[ea[9:2]], 32'hA5A5_0000 + 32'(i)); end
    end
  endtask

  task automatic test_misaligned();
    logic [32*W-1:0] data;
    int lat, log0;
    bit busy_ok;
    data = rand_point();
    log0 = wlog.size();
    run_store(32'h203, data, 32'h0, lat, busy_ok);
    @(negedge clk);
    total++; if (lat != LAT) begin bad++; $display("FAIL misaligned_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < W; i++) begin
      total++; if (wlog[log0 + i] !== {exp_addr(32'h200, i), data[32*i +: 32]}) begin
        bad++; $display("FAIL misaligned_write%0d: got %h want %h", i, wlog[log0 + i], {exp_addr(32'h200, i), data[32*i +: 32]}); end
    end
  endtask

  task automatic test_ignore_start();
    logic [32*W-1:0] data;
    int lat, log0, d0;
    bit busy_ok;
    data = rand_point();
    log0 = wlog.size();
    d0 = done_cnt;
    run_store(32'h140, data, (32'h1 << 1) | (32'h1 << 4) | (32'h1 << 8), lat, busy_ok);
    repeat (4) @(negedge clk);
    total++; if (lat != LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
    total++; if (wlog.size() - log0 != W) begin
      bad++; $display("FAIL ignore_write_count: got %0d want %0d", wlog.size() - log0, W); end
    for (int i = 0; i < W; i++) begin
      total++; if (wlog[log0 + i] !== {exp_addr(32'h140, i), data[32*i +: 32]}) begin
        bad++; $display("FAIL ignore_write%0d: got %h want %h", i, wlog[log0 + i], {exp_addr(32'h140, i), data[32*i +: 32]}); end
    end
  endtask

  task automatic test_wrap();
    logic [32*W-1:0] data;
    int lat, log0;
    bit busy_ok;
    logic [31:0] want_addr;
    data = rand_point();
    log0 = wlog.size();
    run_store(32'hFFFF_FFF0, data, 32'h0, lat, busy_ok);
    @(negedge clk);
    total++; if (lat != LAT) begin bad++; $display("FAIL wrap_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < W; i++) begin
      want_addr = (i < 4) ? 32'hFFFF_FFF0 + 32'(4 * i) : 32'(4 * (i - 4));
      total++; if (wlog[log0 + i] !== {want_addr, data[32*i +: 32]}) begin
        bad++; $display("FAIL wrap_write%0d: got %h want %h", i, wlog[log0 + i], {want_addr, data[32*i +: 32]}); end
    end
  endtask

  task automatic test_reset_mid();
    logic [32*W-1:0] data;
    int lat, log0, d0, nexp;
    bit busy_ok;
    logic [31:0] ea;
    data = rand_point();
    log0 = wlog.size();
    d0 = done_cnt;
    nexp = 0;
    for (int k = 0; k < W; k++) if ((RB ? 2*k + 1 : k + 1) <= 3) nexp++;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 32'h300;
    bus.point_data = data;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b0;
    end
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.err, bus.err_idx, bus.mem_we} !== 8'h0 ||
                 bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL midreset_outputs: got busy=%b done=%b err=%b idx=%0d we=%b addr=%h wdata=%h want all 0",
                      bus.busy, bus.done, bus.err, bus.err_idx, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt - d0); end
    total++; if (wlog.size() - log0 != nexp) begin
      bad++; $display("FAIL midreset_write_count: got %0d want %0d", wlog.size() - log0, nexp); end
    for (int i = 0; i < W; i++) begin
      ea = exp_addr(32'h300, i);
      total++; if (mem[ea[9:2]] !== ((i < nexp) ? data[32*i +: 32] : 32'h0)) begin
        bad++; $display("FAIL midreset_mem[%h]: got %h want %h", ea, mem[ea[9:2]], (i < nexp) ? data[32*i +: 32] : 32'h0); end
    end
    data = rand_point();
    log0 = wlog.size();
    run_store(32'h300, data, 32'h0, lat, busy_ok);
    @(negedge clk);
    total++; if (lat != LAT) begin bad++; $display("FAIL midreset_restart_latency: got %0d want %0d", lat, LAT); end
    for (int i = 0; i < W; i++) begin
      total++; if (wlog[log0 + i] !== {exp_addr(32'h300, i), data[32*i +: 32]}) begin
        bad++; $display("FAIL midreset_restart_write%0d: got %h want %h", i, wlog[log0 + i], {exp_addr(32'h300, i), data[32*i +: 32]}); end
    end
  endtask

  task automatic test_readback();
    logic [32*W-1:0] data;
    int lat;
    bit busy_ok;
    data = rand_point();
    corrupt_base = 32'h180;
    corrupt_en = 1'b1;
    run_store(32'h180, data, 32'h0, lat, busy_ok);
    total++; if (bus.err !== RB) begin bad++; $display("FAIL readback_err: got %b want %b", bus.err, RB); end
    total++; if (bus.err_idx !== (RB ? 4'd3 : 4'd0)) begin
      bad++; $display("FAIL readback_err_idx: got %0d want %0d", bus.err_idx, RB ? 3 : 0); end
    corrupt_en = 1'b0;
    run_store(32'h180, rand_point(), 32'h0, lat, busy_ok);
    total++; if (bus.err !== 1'b0 || bus.err_idx !== 4'd0) begin
      bad++; $display("FAIL readback_clear: got err=%b idx=%0d want 0 0", bus.err, bus.err_idx); end
  endtask

  // Consecutive runs: each start lands the cycle after the previous done.
  task automatic test_back_to_back();
    logic [32*W-1:0] data;
    logic [31:0] base;
    int lat, log0;
    bit busy_ok;
    for (int t = 0; t < 6; t++) begin
      data = rand_point();
      base = $urandom();
      log0 = wlog.size();
      run_store(base, data, 32'h0, lat, busy_ok);
      total++; if (lat != LAT || !busy_ok) begin
        bad++; $display("FAIL b2b%0d_timing: got lat=%0d busy_ok=%0d want lat=%0d busy_ok=1", t, lat, busy_ok, LAT); end
      for (int i = 0; i < W; i++) begin
        total++; if (wlog[log0 + i] !== {exp_addr(base, i), data[32*i +: 32]}) begin
          bad++; $display("FAIL b2b%0d_write%0d: got %h want %h", t, i, wlog[log0 + i], {exp_addr(base, i), data[32*i +: 32]}); end
      end
    end
    @(negedge clk);
    total++; if (same_addr_viol) begin bad++; $display("FAIL same_addr_repeat: got repeat want none"); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = 32'h0;
    bus.point_data = '0;
    test_reset();
    test_basic();
    test_misaligned();
    test_ignore_start();
    test_wrap();
    test_reset_mid();
    test_readback();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
